// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control path: state codes, opcodes,
// ALU/PC mux selects and the packed control vector.
package mc_pkg;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_R_EXEC    = 4'd6,
    ST_R_WB      = 4'd7,
    ST_BRANCH    = 4'd8,
    ST_JUMP      = 4'd9,
    ST_I_EXEC    = 4'd10,
    ST_I_WB      = 4'd11
  } state_t;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_ADDI  = 6'h08;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = ctrl_t'(16'h0000);

  // Final state of each instruction class; MEM_WRITE only retires once memory accepts.
  function automatic logic is_retire(input state_t s, input logic mem_ready);
    case (s)
      ST_MEM_WB, ST_R_WB, ST_BRANCH, ST_JUMP, ST_I_WB: is_retire = 1'b1;
      ST_MEM_WRITE:                                    is_retire = mem_ready;
      default:                                         is_retire = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Moore decode of the control-unit state into the datapath control vector.
// Only FETCH looks at mem_ready, to hold IR/PC writes until the read lands.
module mc_ctrl_decode
  import mc_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  // Per-state control vector; anything not set stays 0.
  always_comb begin
    ctrl = CTRL_IDLE;
    case (state)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        if (mem_ready) begin
          ctrl.ir_write = 1'b1;
          ctrl.pc_write = 1'b1;
        end else begin
          ctrl.ir_write = 1'b0;
          ctrl.pc_write = 1'b0;
        end
      end
      ST_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ST_MEM_ADDR, ST_I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ST_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      ST_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      ST_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNC;
      end
      ST_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      ST_I_WB: begin
        ctrl.reg_write = 1'b1;
      end
      default: ctrl = CTRL_IDLE;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute, flags
// illegal opcodes and counts retired instructions.
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter int         CNT_W    = 32,
  parameter logic [5:0] OP_RTYPE = OPC_RTYPE,
  parameter logic [5:0] OP_LW    = OPC_LW,
  parameter logic [5:0] OP_SW    = OPC_SW,
  parameter logic [5:0] OP_BEQ   = OPC_BEQ,
  parameter logic [5:0] OP_J     = OPC_J,
  parameter logic [5:0] OP_ADDI  = OPC_ADDI
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             IRwrite,
  output logic             PCwrite,
  output logic             PCwriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       state_o,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  state_t           state_r;
  state_t           next_state_s;
  logic             illegal_s;
  logic             illegal_r;
  logic             retire_s;
  logic [CNT_W-1:0] count_r;
  ctrl_t            ctrl_s;
  ctrl_t            out_s;

  // State, illegal-opcode flag and retire counter; reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_FETCH;
      illegal_r <= 1'b0;
      count_r   <= '0;
    end else begin
      state_r   <= next_state_s;
      illegal_r <= illegal_s;
      if (retire_s) begin
        count_r <= count_r + CNT_W'(1);
      end else begin
        count_r <= count_r;
      end
    end
  end

  // Next-state selection; codes 12-15 fall through to FETCH.
  always_comb begin
    next_state_s = ST_FETCH;
    illegal_s    = 1'b0;
    case (state_r)
      ST_FETCH:     next_state_s = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        if (opcode == OP_LW || opcode == OP_SW) begin
          next_state_s = ST_MEM_ADDR;
        end else if (opcode == OP_RTYPE) begin
          next_state_s = ST_R_EXEC;
        end else if (opcode == OP_BEQ) begin
          next_state_s = ST_BRANCH;
        end else if (opcode == OP_J) begin
          next_state_s = ST_JUMP;
        end else if (opcode == OP_ADDI) begin
          next_state_s = ST_I_EXEC;
        end else begin
          next_state_s = ST_FETCH;
          illegal_s    = 1'b1;
        end
      end
      ST_MEM_ADDR: begin
        if (opcode == OP_LW) begin
          next_state_s = ST_MEM_READ;
        end else if (opcode == OP_SW) begin
          next_state_s = ST_MEM_WRITE;
        end else begin
          next_state_s = ST_FETCH;
        end
      end
      ST_MEM_READ:  next_state_s = mem_ready ? ST_MEM_WB : ST_MEM_READ;
      ST_MEM_WRITE: next_state_s = mem_ready ? ST_FETCH : ST_MEM_WRITE;
      ST_R_EXEC:    next_state_s = ST_R_WB;
      ST_I_EXEC:    next_state_s = ST_I_WB;
      default:      next_state_s = ST_FETCH;
    endcase
    retire_s = (next_state_s == ST_FETCH) && is_retire(state_r, mem_ready);
  end

  mc_ctrl_decode u_decode (
    .state     (state_r),
    .mem_ready (mem_ready),
    .ctrl      (ctrl_s)
  );

  // Control outputs are forced low for as long as rst is held.
  always_comb begin
    if (rst) begin
      out_s = CTRL_IDLE;
    end else begin
      out_s = ctrl_s;
    end
  end

  assign IRwrite     = out_s.ir_write;
  assign PCwrite     = out_s.pc_write;
  assign PCwriteCond = out_s.pc_write_cond;
  assign IorD        = out_s.i_or_d;
  assign MemRead     = out_s.mem_read;
  assign MemWrite    = out_s.mem_write;
  assign MemtoReg    = out_s.mem_to_reg;
  assign RegDst      = out_s.reg_dst;
  assign RegWrite    = out_s.reg_write;
  assign ALUSrcA     = out_s.alu_src_a;
  assign ALUSrcB     = out_s.alu_src_b;
  assign ALUOp       = out_s.alu_op;
  assign PCSource    = out_s.pc_source;
  assign state_o     = state_r;
  assign illegal_op  = illegal_r;
  assign instr_count = count_r;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed-vector bench for mc_control_fsm; inputs change and outputs are
// sampled on the falling edge, away from the active rising edge.
module tb_mc_control_fsm;

  logic        clk;
  logic        rst;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        IRwrite, PCwrite, PCwriteCond, IorD, MemRead, MemWrite;
  logic        MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0]  ALUSrcB, ALUOp, PCSource;
  logic [3:0]  state_o;
  logic        illegal_op;
  logic [31:0] instr_count;

  int n_checks = 0;
  int n_pass   = 0;

  mc_control_fsm #(.CNT_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .mem_ready   (mem_ready),
    .IRwrite     (IRwrite),
    .PCwrite     (PCwrite),
    .PCwriteCond (PCwriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSource    (PCSource),
    .state_o     (state_o),
    .illegal_op  (illegal_op),
    .instr_count (instr_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [15:0] ctrl_bus;
  assign ctrl_bus = {IRwrite, PCwrite, PCwriteCond, IorD, MemRead, MemWrite, MemtoReg,
                     RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

  initial begin
    int mw_cycles;
    int cycles;
    logic [3:0] lw_seq [5];
    lw_seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};

    rst       = 1'b1;
    opcode    = 6'h23;
    mem_ready = 1'b1;
    @(negedge clk);
    check("rst_state", {28'd0, state_o}, 32'd0);
    check("rst_ctrl", {16'd0, ctrl_bus}, 32'd0);
    check("rst_count", instr_count, 32'd0);
    check("rst_illegal", {31'd0, illegal_op}, 32'd0);
    rst = 1'b0;
    #1;
    check("fetch_memread", {31'd0, MemRead}, 32'd1);
    // FETCH with ready: MemRead,IRwrite,PCwrite, ALUSrcB=01
    check("fetch_ctrl", {16'd0, ctrl_bus}, {16'd0, 16'b1100_1000_0001_0000});

    // lw: 0,1,2,3,4,0
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("lw_state%0d", i), {28'd0, state_o}, {28'd0, lw_seq[i]});
      if (i == 0) check("decode_srcb", {30'd0, ALUSrcB}, 32'd3);
      if (i == 2) check("memread_iord", {30'd0, MemRead, IorD}, 32'd3);
      if (i == 3) check("lw_wb", {29'd0, MemtoReg, RegWrite, RegDst}, 32'b110);
    end
    check("lw_count", instr_count, 32'd1);

    // sw with 3 cycles of mem_ready low in MEM_WRITE
    opcode = 6'h2B;
    mw_cycles = 0;
    cycles = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (state_o == 4'd0) break;
      cycles++;
      if (MemWrite) mw_cycles++;
      if (state_o == 4'd5) mem_ready = (mw_cycles >= 4);
    end
    check("sw_state_end", {28'd0, state_o}, 32'd0);
    check("sw_memwrite_cycles", mw_cycles, 32'd4);
    check("sw_total_cycles", cycles, 32'd7);
    check("sw_count", instr_count, 32'd2);

    // Fetch stall for two cycles, then beq
    opcode    = 6'h04;
    mem_ready = 1'b0;
    #1;
    check("stall1_irpc", {30'd0, IRwrite, PCwrite}, 32'd0);
    @(negedge clk);
    check("stall2_state", {28'd0, state_o}, 32'd0);
    check("stall2_irpc", {30'd0, IRwrite, PCwrite}, 32'd0);
    mem_ready = 1'b1;
    #1;
    check("ready_irpc", {30'd0, IRwrite, PCwrite}, 32'd3);
    @(negedge clk);
    check("beq_decode", {28'd0, state_o}, 32'd1);
    check("decode_irwrite", {31'd0, IRwrite}, 32'd0);
    @(negedge clk);
    check("beq_state", {28'd0, state_o}, 32'd8);
    check("beq_ctrl", {28'd0, PCwriteCond, ALUOp[0], PCSource}, 32'b1101);
    @(negedge clk);
    check("beq_done", {28'd0, state_o}, 32'd0);
    check("beq_count", instr_count, 32'd3);

    // jump
    opcode = 6'h02;
    @(negedge clk);
    @(negedge clk);
    check("j_state", {28'd0, state_o}, 32'd9);
    check("j_ctrl", {16'd0, ctrl_bus}, {16'd0, 16'b0100_0000_0000_0010});
    @(negedge clk);
    check("j_done", {28'd0, state_o}, 32'd0);
    check("j_count", instr_count, 32'd4);

    // illegal opcode
    opcode = 6'h3F;
    @(negedge clk);
    check("ill_pre", {31'd0, illegal_op}, 32'd0);
    @(negedge clk);
    check("ill_state", {28'd0, state_o}, 32'd0);
    check("ill_pulse", {31'd0, illegal_op}, 32'd1);
    check("ill_count", instr_count, 32'd4);
    opcode = 6'h00;
    @(negedge clk);
    check("ill_pulse_end", {31'd0, illegal_op}, 32'd0);
    check("r_decode", {28'd0, state_o}, 32'd1);
    @(negedge clk);
    check("r_exec", {28'd0, state_o}, 32'd6);
    check("r_aluop", {29'd0, ALUOp, ALUSrcA}, 32'b101);
    @(negedge clk);
    check("r_wb", {28'd0, state_o}, 32'd7);
    check("r_wb_ctrl", {29'd0, RegWrite, RegDst, MemtoReg}, 32'b110);
    @(negedge clk);
    check("r_done", {28'd0, state_o}, 32'd0);
    check("r_count", instr_count, 32'd5);

    // Reset mid-MEM_READ
    opcode = 6'h23;
    @(negedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    check("mr_state", {28'd0, state_o}, 32'd3);
    check("mr_memread", {31'd0, MemRead}, 32'd1);
    rst = 1'b1;
    #1;
    check("mr_rst_state", {28'd0, state_o}, 32'd0);
    check("mr_rst_ctrl", {16'd0, ctrl_bus}, 32'd0);
    check("mr_rst_count", instr_count, 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    mem_ready = 1'b1;
    #1;
    check("post_rst_memread", {31'd0, MemRead}, 32'd1);
    check("post_rst_count", instr_count, 32'd0);
    @(negedge clk);
    check("post_rst_decode", {28'd0, state_o}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle MIPS main control unit. Sequences the instruction register, register file, ALU, PC and unified memory.
- Drives IRwrite to the instruction register in FETCH and consumes the decoded opcode/func.
- Emits one-hot-per-state Moore control signals, waits on a memory-ready handshake, flags illegal opcodes and counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter
- OP_RTYPE, 6'h00, R-type opcode
- OP_LW, 6'h23, load word opcode
- OP_SW, 6'h2B, store word opcode
- OP_BEQ, 6'h04, branch-equal opcode
- OP_J, 6'h02, jump opcode
- OP_ADDI, 6'h08, add-immediate opcode

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-high
- opcode  in  6  from instruction register
- mem_ready  in  1  memory completes current read/write this cycle
- IRwrite  out  1  load instruction register
- PCwrite  out  1  unconditional PC write
- PCwriteCond  out  1  PC write if ALU zero
- IorD  out  1  0 = PC addresses memory, 1 = ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- MemtoReg  out  1  writeback source: 1 = MDR, 0 = ALUOut
- RegDst  out  1  1 = rd, 0 = rt
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0 = PC, 1 = A
- ALUSrcB  out  2  00 = B, 01 = const 4, 10 = signext, 11 = signext<<2
- ALUOp  out  2  00 = add, 01 = sub, 10 = func-field
- PCSource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
- state_o  out  4  current state encoding, for debug
- illegal_op  out  1  one-cycle pulse on unknown opcode
- instr_count  out  CNT_W  retired instructions

Behaviour:
- States and encodings:
  - FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_READ = 3, MEM_WB = 4, MEM_WRITE = 5
  - R_EXEC = 6, R_WB = 7, BRANCH = 8, JUMP = 9, I_EXEC = 10, I_WB = 11
  - Encodings 12–15 are unused and return to FETCH on the next edge.
- Reset: while rst = 1, state = FETCH, instr_count = 0, illegal_op = 0, and every control output is forced to 0. The first cycle after release is FETCH.
- Reset asserted mid-instruction aborts it at once. No pending write completes, and instr_count does not increment.
- Control outputs are a combinational decode of the state register, gated by rst. Any signal not listed for a state is 0.
- FETCH:
  - Always asserted: MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSource = 00.
  - IRwrite and PCwrite are asserted only when mem_ready = 1.
  - Stays in FETCH while mem_ready = 0. Goes to DECODE when mem_ready = 1.
- DECODE:
  - ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00.
  - Next state by opcode: lw/sw → MEM_ADDR; R-type → R_EXEC; beq → BRANCH; j → JUMP; addi → I_EXEC.
  - Any other opcode → FETCH, with illegal_op pulsed on that edge. instr_count is not incremented.
- MEM_ADDR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Next state is MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: MemRead = 1, IorD = 1. Holds until mem_ready = 1, then goes to MEM_WB.
- MEM_WB: RegWrite = 1, RegDst = 0, MemtoReg = 1. Next state FETCH.
- MEM_WRITE: MemWrite = 1, IorD = 1. Holds until mem_ready = 1, then goes to FETCH.
- R_EXEC: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10. Next state R_WB.
- R_WB: RegWrite = 1, RegDst = 1, MemtoReg = 0. Next state FETCH.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCwriteCond = 1, PCSource = 01. Next state FETCH.
- JUMP: PCwrite = 1, PCSource = 10. Next state FETCH.
- I_EXEC: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Next state I_WB.
- I_WB: RegWrite = 1, RegDst = 0, MemtoReg = 0. Next state FETCH.
- instr_count increments by 1 on every edge whose next state is FETCH and whose current state is MEM_WB, MEM_WRITE (with mem_ready = 1), R_WB, BRANCH, JUMP or I_WB. It wraps modulo 2^CNT_W.
- Latency with mem_ready held at 1: lw = 5 cycles, sw/R-type/addi = 4, beq/j = 3. Each cycle of mem_ready = 0 in a wait state adds one cycle.
- Opcode is sampled only in DECODE and MEM_ADDR. It is held stable by the instruction register, because IRwrite is low outside FETCH.

Decomposition:
- Shared package mc_pkg holds:
  - state enum/localparams;
  - opcode constants;
  - ALUOp, ALUSrcB and PCSource encodings.
- These are shared with the ALU control block and the datapath.
- One sub-module is natural: mc_ctrl_decode, a pure combinational state → control-vector decode.
- The FSM and counter stay in the top module.

Test Plan:
- Reset: assert rst mid-MEM_READ → all outputs 0 immediately and state_o = 0; after release FETCH asserts MemRead = 1 and instr_count = 0.
- lw with opcode = 6'h23, mem_ready = 1 → state_o sequence 0,1,2,3,4,0. MemtoReg = 1 and RegWrite = 1 in state 4. instr_count becomes 1.
- sw with opcode = 6'h2B, mem_ready low for 3 cycles in MEM_WRITE → MemWrite held for 4 cycles; exit on mem_ready; total 7 cycles.
- Fetch stall: mem_ready = 0 for 2 cycles in FETCH → IRwrite = 0 and PCwrite = 0 while stalled; both = 1 only in the ready cycle.
- Branch/jump: beq (6'h04) gives PCwriteCond = 1 and PCSource = 01 in state 8. j (6'h02) gives PCwrite = 1 and PCSource = 10 in state 9. Each takes 3 cycles.
- Illegal opcode 6'h3F → DECODE→FETCH, illegal_op is a single-cycle pulse, instr_count unchanged; then an R-type (6'h00) completes in 4 cycles with ALUOp = 10 and RegDst = 1.
